// File: rtl/group_add_arbiter.sv
// Round-robin sharing of one pipelined group_add adder tree between REQ_NB
// requesters, with a tag pipeline and a credit-guarded show-ahead output FIFO.

module group_add #(
  parameter int GROUP_NB    = 4,
  parameter int NUM_WIDTH   = 16,
  parameter int ADD_LATENCY = 2
) (
  input  logic                          clk,
  input  logic [GROUP_NB*NUM_WIDTH-1:0] up_data,
  output logic [NUM_WIDTH-1:0]          dn_data
);

  logic [NUM_WIDTH-1:0] sum_c;
  logic [NUM_WIDTH-1:0] stage [ADD_LATENCY];

  // Modular wrap: two's-complement lanes summed in NUM_WIDTH bits.
  always_comb begin
    sum_c = '0;
    for (int l = 0; l < GROUP_NB; l++) begin
      sum_c = sum_c + up_data[l*NUM_WIDTH +: NUM_WIDTH];
    end
  end

  // NOTE: datapath registers carry no reset; the tag pipeline says which
  // stage holds a real result, so clearing the data would only cost gates.
  always_ff @(posedge clk) begin
    stage[0] <= sum_c;
    for (int s = 1; s < ADD_LATENCY; s++) begin
      stage[s] <= stage[s-1];
    end
  end

  assign dn_data = stage[ADD_LATENCY-1];

endmodule

module group_add_arbiter #(
  parameter int REQ_NB      = 4,
  parameter int GROUP_NB    = 4,
  parameter int NUM_WIDTH   = 16,
  parameter int ADD_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ID_WIDTH    = (REQ_NB > 1) ? $clog2(REQ_NB) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [REQ_NB*NUM_WIDTH*GROUP_NB-1:0]   up_data,
  input  logic [REQ_NB-1:0]                      up_valid,
  output logic [REQ_NB-1:0]                      up_ready,
  output logic [NUM_WIDTH-1:0]                   dn_data,
  output logic [ID_WIDTH-1:0]                    dn_id,
  output logic                                   dn_valid,
  input  logic                                   dn_ready,
  output logic                                   idle
);

  localparam int VEC_W = NUM_WIDTH * GROUP_NB;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [CNT_W-1:0]     cnt;
  logic [ID_WIDTH-1:0]  last;
  logic [ID_WIDTH-1:0]  grant_id;
  logic                 grant_found;
  logic                 credit_ok;
  logic                 issue;
  logic                 pop;
  logic                 push;
  logic [VEC_W-1:0]     issue_data;
  logic [NUM_WIDTH-1:0] add_sum;

  logic                 tag_valid [ADD_LATENCY];
  logic [ID_WIDTH-1:0]  tag_id    [ADD_LATENCY];

  logic [NUM_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]  mem_id   [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;

  // Arbiter: scan from last+1 and wrap, first valid requester wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_id    = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= REQ_NB; k++) begin
      idx = (int'(last) + k) % REQ_NB;
      if (!grant_found && up_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_WIDTH'(idx);
      end
    end
  end

  assign credit_ok = (cnt < CNT_W'(FIFO_DEPTH));

  always_comb begin
    up_ready = '0;
    if (rst && grant_found && credit_ok) begin
      up_ready[grant_id] = 1'b1;
    end
  end

  assign issue      = |up_ready;
  assign issue_data = issue ? up_data[int'(grant_id)*VEC_W +: VEC_W] : '0;
  assign pop        = dn_valid && dn_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      last <= ID_WIDTH'(REQ_NB - 1);
    end else begin
      if (issue && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (!issue && pop) begin
        cnt <= cnt - 1'b1;
      end
      if (issue) begin
        last <= grant_id;
      end
    end
  end

  group_add #(
    .GROUP_NB   (GROUP_NB),
    .NUM_WIDTH  (NUM_WIDTH),
    .ADD_LATENCY(ADD_LATENCY)
  ) u_group_add (
    .clk    (clk),
    .up_data(issue_data),
    .dn_data(add_sum)
  );

  // Tag pipeline mirrors the adder depth so the exit tag lines up with add_sum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < ADD_LATENCY; s++) begin
        tag_valid[s] <= 1'b0;
        tag_id[s]    <= '0;
      end
    end else begin
      tag_valid[0] <= issue;
      tag_id[0]    <= grant_id;
      for (int s = 1; s < ADD_LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  assign push = tag_valid[ADD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
    end
  end

  // NOTE: storage array is not reset; emptiness is tracked by fifo_cnt and the
  // head is masked while empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= add_sum;
      mem_id[wr_ptr]   <= tag_id[ADD_LATENCY-1];
    end
  end

  assign dn_valid = (fifo_cnt != '0);
  assign dn_data  = dn_valid ? mem_data[rd_ptr] : '0;
  assign dn_id    = dn_valid ? mem_id[rd_ptr]   : '0;
  assign idle     = (cnt == '0);

`ifdef SIMULATION
  always @(posedge clk) begin
    if (rst) begin
      assert (!(push && !pop && fifo_cnt == CNT_W'(FIFO_DEPTH)))
        else $error("group_add_arbiter: output FIFO overflow");
    end
  end
`endif

endmodule

// File: tb/tb_group_add_arbiter.sv
// Self-checking bench for group_add_arbiter: directed scenarios plus random
// traffic compared cycle by cycle against a queue-based reference model.

module tb_group_add_arbiter;

  localparam int REQ_NB      = 4;
  localparam int GROUP_NB    = 4;
  localparam int NUM_WIDTH   = 16;
  localparam int ADD_LATENCY = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int ID_WIDTH    = 2;
  localparam int VEC_W       = NUM_WIDTH * GROUP_NB;

  logic                        clk;
  logic                        rst;
  logic [REQ_NB*VEC_W-1:0]     up_data;
  logic [REQ_NB-1:0]           up_valid;
  logic [REQ_NB-1:0]           up_ready;
  logic [NUM_WIDTH-1:0]        dn_data;
  logic [ID_WIDTH-1:0]         dn_id;
  logic                        dn_valid;
  logic                        dn_ready;
  logic                        idle;

  group_add_arbiter #(
    .REQ_NB     (REQ_NB),
    .GROUP_NB   (GROUP_NB),
    .NUM_WIDTH  (NUM_WIDTH),
    .ADD_LATENCY(ADD_LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ID_WIDTH   (ID_WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .up_data (up_data),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .dn_data (dn_data),
    .dn_id   (dn_id),
    .dn_valid(dn_valid),
    .dn_ready(dn_ready),
    .idle    (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: results in flight with a countdown, then a plain queue.
  typedef struct {
    logic [NUM_WIDTH-1:0] data;
    int                   id;
    int                   rem;
  } item_t;

  item_t flight_q[$];
  item_t fifo_q[$];
  int    m_cnt  = 0;
  int    m_last = REQ_NB - 1;

  logic [REQ_NB-1:0]    obs_up_ready;
  logic [NUM_WIDTH-1:0] obs_dn_data;
  logic [ID_WIDTH-1:0]  obs_dn_id;
  logic                 obs_dn_valid;
  logic                 obs_idle;

  function automatic logic [NUM_WIDTH-1:0] vec_sum(input int req);
    int s;
    s = 0;
    for (int l = 0; l < GROUP_NB; l++) begin
      s += int'($signed(up_data[req*VEC_W + l*NUM_WIDTH +: NUM_WIDTH]));
    end
    return NUM_WIDTH'(s);
  endfunction

  task automatic set_vec(input int req, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    up_data[req*VEC_W +: VEC_W] = {d, c, b, a};
  endtask

  task automatic rand_data();
    for (int w = 0; w < REQ_NB*VEC_W/32; w++) begin
      up_data[w*32 +: 32] = $urandom;
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic [REQ_NB-1:0] v, input logic dr, input logic r);
    logic [REQ_NB-1:0]    er;
    logic [NUM_WIDTH-1:0] ed;
    logic [NUM_WIDTH-1:0] new_sum;
    int                   eid;
    int                   g;
    bit                   m_pop;
    item_t                it;
    up_valid = v;
    dn_ready = dr;
    rst      = r;
    #1;
    er = '0;
    g  = -1;
    if (r && m_cnt < FIFO_DEPTH) begin
      for (int k = 1; k <= REQ_NB; k++) begin
        int idx = (m_last + k) % REQ_NB;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    ed  = (fifo_q.size() > 0) ? fifo_q[0].data : '0;
    eid = (fifo_q.size() > 0) ? fifo_q[0].id : 0;
    new_sum = (g >= 0) ? vec_sum(g) : '0;

    obs_up_ready = up_ready;
    obs_dn_data  = dn_data;
    obs_dn_id    = dn_id;
    obs_dn_valid = dn_valid;
    obs_idle     = idle;
    check("up_ready", up_ready, er);
    check("dn_valid", dn_valid, fifo_q.size() > 0);
    check("dn_data",  dn_data,  ed);
    check("dn_id",    dn_id,    eid);
    check("idle",     idle,     m_cnt == 0);

    @(posedge clk);
    if (!r) begin
      flight_q.delete();
      fifo_q.delete();
      m_cnt  = 0;
      m_last = REQ_NB - 1;
    end else begin
      m_pop = (fifo_q.size() > 0) && dr;
      if (m_pop) void'(fifo_q.pop_front());
      foreach (flight_q[j]) flight_q[j].rem--;
      if (flight_q.size() > 0 && flight_q[0].rem == 0) begin
        fifo_q.push_back(flight_q[0]);
        void'(flight_q.pop_front());
      end
      if (g >= 0) begin
        it.data = new_sum;
        it.id   = g;
        it.rem  = ADD_LATENCY;
        flight_q.push_back(it);
        m_last = g;
      end
      m_cnt += ((g >= 0) ? 1 : 0) - (m_pop ? 1 : 0);
    end
    @(negedge clk);
  endtask

  // Lone vector from one requester: result, tag, latency, and return to idle.
  task automatic send_one(input int req, input logic [NUM_WIDTH-1:0] exp_sum, input string tag);
    logic [REQ_NB-1:0] v;
    int first;
    v = '0;
    v[req] = 1'b1;
    step(v, 1'b1, 1'b1);
    check({tag, "_hs"}, obs_up_ready, v);
    first = -1;
    for (int k = 1; k <= 8; k++) begin
      step('0, 1'b1, 1'b1);
      if (obs_dn_valid && first < 0) begin
        first = k;
        check({tag, "_data"}, obs_dn_data, exp_sum);
        check({tag, "_id"}, obs_dn_id, req);
      end
    end
    check({tag, "_lat"}, first, ADD_LATENCY + 1);
    check({tag, "_idle"}, obs_idle, 1);
  endtask

  initial begin
    int n_issue;
    rst      = 1'b0;
    up_valid = '0;
    dn_ready = 1'b0;
    up_data  = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    step('0, 1'b0, 1'b0);

    // Single vector, Q8.8 {4,3,2,1} from requester 2
    set_vec(2, 16'h0400, 16'h0300, 16'h0200, 16'h0100);
    send_one(2, 16'h0A00, "single");

    // Round robin from a fresh reset
    step('0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      rand_data();
      step('1, 1'b1, 1'b1);
      check("rr_grant", obs_up_ready, 4'b0001 << (k % 4));
    end
    for (int k = 0; k < 8; k++) step('0, 1'b1, 1'b1);

    // Back-pressure: credits run out, head held, then drain in order
    n_issue = 0;
    for (int k = 0; k < 8; k++) begin
      rand_data();
      step('1, 1'b0, 1'b1);
      if (obs_up_ready != '0) n_issue++;
    end
    check("bp_issues", n_issue, FIFO_DEPTH);
    for (int k = 0; k < 10; k++) step('1, 1'b0, 1'b1);
    step('1, 1'b1, 1'b1);
    check("bp_full", obs_up_ready, 0);
    step('1, 1'b1, 1'b1);
    check("bp_resume", obs_up_ready != '0, 1);
    for (int k = 0; k < 10; k++) step('0, 1'b1, 1'b1);

    // Wrap arithmetic
    set_vec(0, 16'h7F00, 16'h0200, 16'h0000, 16'h0000);
    send_one(0, 16'h8100, "wrap_pos");
    set_vec(1, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
    send_one(1, 16'hFC00, "wrap_neg");

    // Reset mid-flight
    for (int k = 0; k < 3; k++) begin
      rand_data();
      step('1, 1'b0, 1'b1);
    end
    step('0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step('0, 1'b1, 1'b1);
      check("rst_nvalid", obs_dn_valid, 0);
      check("rst_idle", obs_idle, 1);
    end
    rand_data();
    step('1, 1'b1, 1'b1);
    check("rst_grant", obs_up_ready, 4'b0001);

    // Fairness with only requesters 1 and 3 active
    for (int k = 0; k < 12; k++) begin
      rand_data();
      step(4'b1010, 1'b1, 1'b1);
      check("fair_grant", obs_up_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
    end
    for (int k = 0; k < 6; k++) step('0, 1'b1, 1'b1);

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      rand_data();
      step(REQ_NB'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 63) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
